// File: rtl/shift_add_pkg.sv
// -----------------------------------------------------------------------------
// shift_add_pkg
// Shared definitions for the shift-and-add multiplier.
//   state_t : controller states (S_IDLE, S_RUN, S_DONE)
// -----------------------------------------------------------------------------
package shift_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_n.sv
// -----------------------------------------------------------------------------
// adder_n
// N-bit ripple-carry adder built from per-bit full-adder cells.
// Ports:
//   a, b   : N-bit addends
//   c_in   : carry in
//   sum    : N-bit sum
//   c_out  : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] carry;

  assign carry[0] = c_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned N x N -> 2N multiplier, one partial product per cycle.
// The product register P holds the running high half in P[2N-1:N] and the
// not-yet-consumed multiplier bits in P[N-1:0]; each S_RUN cycle conditionally
// adds the multiplicand into the high half and shifts the whole register right.
//
// Ports:
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-high reset
//   in_valid   : operands a/b present
//   in_ready   : high in S_IDLE only
//   a, b       : unsigned multiplicand / multiplier (N bits)
//   out_valid  : high in S_DONE only
//   out_ready  : consumer takes product (only looked at in S_DONE)
//   product    : 2N-bit registered result
//
// Build option: define SHIFT_ADD_ZERO_BYPASS_EN to skip straight to S_DONE
// with a zero product when either operand is zero on accept.
// -----------------------------------------------------------------------------
module shift_add_multiplier
  import shift_add_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [2*N-1:0]   p_reg;
  logic [N-1:0]     mcand_reg;
  logic [CW-1:0]    count_reg;

  logic [N-1:0]     addend;
  logic [N-1:0]     hi_sum;
  logic             hi_carry;
  logic             bypass_hit;

`ifdef SHIFT_ADD_ZERO_BYPASS_EN
  assign bypass_hit = (a == '0) || (b == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  // Partial product: add the multiplicand only when the current LSB is set.
  assign addend = p_reg[0] ? mcand_reg : '0;

  adder_n #(
    .N(N)
  ) u_adder (
    .a     (p_reg[2*N-1:N]),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (hi_sum),
    .c_out (hi_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          state_next = bypass_hit ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (count_reg == LAST_STEP) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so no input reaches them combinationally.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg     <= '0;
      mcand_reg <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            mcand_reg <= a;
            count_reg <= '0;
            p_reg     <= bypass_hit ? '0 : {{N{1'b0}}, b};
          end
        end
        S_RUN: begin
          // The adder carry becomes the new MSB; the consumed multiplier bit falls off.
          p_reg <= {hi_carry, hi_sum, p_reg[N-1:1]};
          // Hold on the final step so the counter never wraps for power-of-two N.
          if (count_reg != LAST_STEP) begin
            count_reg <= count_reg + CW'(1);
          end
        end
        default: begin
          p_reg     <= p_reg;
          mcand_reg <= mcand_reg;
          count_reg <= count_reg;
        end
      endcase
    end
  end

  assign product = p_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  int checks;
  int errors;
  bit rand_mode;
  logic [2*N-1:0] sb_q[$];

  shift_add_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Edges from accept (inclusive) until out_valid is first seen.
  function automatic int exp_lat(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 1;
`endif
    return N + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Issue one operation; expected product supplied by the caller.
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [2*N-1:0] exp, input bit measure);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got 0 required 1 within 100 cycles");
      return;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    if (measure) begin
      lat = 1;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      check($sformatf("latency_%0dx%0d", x, y), lat, exp_lat(x, y));
    end
  endtask

  // Monitor / scoreboard: one comparison per product handed over.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got product %0d required no output", product);
        end else begin
          logic [2*N-1:0] e;
          e = sb_q.pop_front();
          checks++;
          if (product !== e) begin
            errors++;
            $display("FAIL product: got %0d required %0d", product, e);
          end else if (!rand_mode) begin
            $display("ok   product: %0d", product);
          end
        end
      end
    end
  end

  initial begin
    int w;
    checks    = 0;
    errors    = 0;
    rand_mode = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    tick();
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    rst = 1'b0;
    tick();

    // 3*5 with immediate drain, then back to idle
    out_ready = 1'b1;
    do_op(8'd3, 8'd5, 16'd15, 1'b1);
    tick();
    check("idle_after_drain", in_ready, 1);

    do_op(8'd255, 8'd255, 16'hFE01, 1'b1);
    tick();
    do_op(8'd128, 8'd2, 16'd256, 1'b1);
    tick();

    // Stall: out_ready low for 5 cycles, new in_valid must be ignored
    out_ready = 1'b0;
    do_op(8'd7, 8'd9, 16'd63, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 8'd1;
      b = 8'd1;
      tick();
      check($sformatf("stall_product_%0d", i), product, 63);
      check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
      check($sformatf("stall_out_valid_%0d", i), out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_drained", in_ready, 1);
    tick();
    tick();

    // Reset in the 4th S_RUN cycle of 200*100
    do_op(8'd200, 8'd100, 16'd20000, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_product", product, 0);
    for (int i = 0; i < N + 2; i++) tick();
    check("midrun_rst_no_pulse", out_valid, 0);
    do_op(8'd2, 8'd3, 16'd6, 1'b1);
    tick();

    // Zero operand
    do_op(8'd0, 8'd77, 16'd0, 1'b1);
    tick();

    // Random back-to-back with random out_ready stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      x = N'($urandom_range(0, 255));
      y = N'($urandom_range(0, 255));
      do_op(x, y, (2*N)'(x) * (2*N)'(y), 1'b0);
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    check("scoreboard_empty", sb_q.size(), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have port in_valid  input  1  operands a/b present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  unsigned multiplicand.
REQ-007 SHALL have port b  input  N  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes product.
REQ-010 SHALL have port product  output  2N  unsigned a*b, registered.

Function
REQ-011 SHALL implement a three-state FSM: S_IDLE, S_RUN, S_DONE.
REQ-012 SHALL drive in_ready=1 only in S_IDLE and out_valid=1 only in S_DONE, both decoded from state only, with no combinational path from inputs.
REQ-013 SHALL accept on a posedge with in_valid&&in_ready: load mcand<=a, P[N-1:0]<=b, P[2N-1:N]<=0, count<=0, state<=S_RUN.
REQ-014 SHALL, per S_RUN cycle: {c,hi}=P[2N-1:N]+(P[0]?mcand:0) via the adder sub-module with c_in=0; then P<={c,hi,P[N-1:1]}; count<=count+1.
REQ-015 SHALL transition S_RUN->S_DONE on the edge where count==N-1, so out_valid rises exactly N+1 edges after the accepting edge.
REQ-016 SHALL drive product=P continuously; product is guaranteed equal to a*b mod 2^(2N) (never overflows) while out_valid=1.
REQ-017 SHALL hold product and out_valid stable in S_DONE until a posedge with out_ready=1, then go to S_IDLE.
REQ-018 SHALL ignore in_valid outside S_IDLE; operand changes during S_RUN/S_DONE have no effect.
REQ-019 SHALL ignore out_ready outside S_DONE.
REQ-020 SHALL allow back-to-back operation: minimum accept-to-accept spacing N+2 edges with out_ready held high.
REQ-021 SHALL size count to $clog2(N) bits and never wrap within an operation.

Reset
REQ-022 SHALL, on any posedge with rst=1 (in any state, including mid-S_RUN), set state=S_IDLE, P=0, mcand=0, count=0; the in-flight operation is discarded, with no out_valid pulse.
REQ-023 SHALL give reset priority over accept and drain on the same edge.
REQ-024 SHALL output in_ready=1, out_valid=0, product=0 after reset.

Configuration
REQ-025 SHALL, with SHIFT_ADD_ZERO_BYPASS_EN defined, go directly from S_IDLE to S_DONE with P=0 on accept when a==0 or b==0 (out_valid one edge after accept).
REQ-026 SHALL, without SHIFT_ADD_ZERO_BYPASS_EN, treat zero operands like any others (N+1 edge latency, product 0).

Structure
REQ-027 SHALL take the state enum type (S_IDLE/S_RUN/S_DONE) from a shared package shift_add_pkg.
REQ-028 SHALL instantiate the existing adder_n (parameter N, ports a, b, c_in, sum, c_out) as its single sub-module for the partial-product add; no behavioural '+' on the datapath.
REQ-029 SHALL keep the count increment as the only other arithmetic.

Verification
REQ-030 SHALL cover: N=8, a=3, b=5, out_ready=1 -> out_valid high 9 edges after accept, product=15, then in_ready=1.
REQ-031 SHALL cover: a=255, b=255 -> product=65025 (16'hFE01); a=128, b=2 -> 256.
REQ-032 SHALL cover: a=7, b=9, out_ready low 5 cycles after out_valid -> product=63 stable, in_ready=0, new in_valid ignored; drains on out_ready=1.
REQ-033 SHALL cover: rst=1 at 4th S_RUN cycle of a=200, b=100 -> next cycle in_ready=1, out_valid=0, product=0; then a=2, b=3 -> product=6.
REQ-034 SHALL cover: a=0, b=77 -> product=0 after 1 edge with SHIFT_ADD_ZERO_BYPASS_EN, after 9 edges without.
REQ-035 SHALL cover: 1000 random a/b back-to-back with random out_ready stalls -> every product === a*b, scoreboard error count 0.
